// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 program loader.
// Contents: loader state encoding, error-flag bit positions, the HLT opcode
// and the instruction word width. No ports.
package mips32_pkg;

    localparam int INSN_W = 32;

    // Bit positions inside the loader's sticky err vector
    localparam int ERR_OVF   = 0;
    localparam int ERR_CKSUM = 1;
    localparam int ERR_TMO   = 2;

    localparam logic [5:0] OP_HLT = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RF_INIT = 3'd1,
        ST_LOAD    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_START   = 3'd4,
        ST_RUN     = 3'd5,
        ST_DONE    = 3'd6
    } loader_state_e;

    // True when an instruction word carries the HLT opcode
    function automatic logic is_hlt(input logic [INSN_W-1:0] insn);
        return (insn[INSN_W-1:INSN_W-6] == OP_HLT);
    endfunction

endpackage

// File: rtl/mips32_loader_cksum.sv
// XOR checksum accumulator for the program loader.
// Ports:
//   clk1, rst      clock and synchronous active-high reset
//   clear          restart the accumulator from seed 0
//   acc_en         fold acc_data into the accumulator this cycle
//   acc_data       word being written to instruction memory
//   cmp_data       candidate checksum word
//   match          accumulator equals cmp_data (combinational)
module mips32_loader_cksum
    import mips32_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [INSN_W-1:0] acc_data,
    input  logic [INSN_W-1:0] cmp_data,
    output logic              match
);

    logic [INSN_W-1:0] acc_r;

    // Running XOR of every word written to memory since the load began
    always_ff @(posedge clk1) begin
        if (rst) begin
            acc_r <= {INSN_W{1'b0}};
        end else if (clear) begin
            acc_r <= {INSN_W{1'b0}};
        end else if (acc_en) begin
            acc_r <= acc_r ^ acc_data;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign match = (acc_r == cmp_data);

endmodule

// File: rtl/mips32_prog_loader.sv
// Program loader for the mips32 core: holds the core, seeds r[k]=k, streams
// a program into instruction memory, starts the core and watches for HLT.
// Optional feature macro: MIPS32_LOADER_CKSUM_EN (s_last word is an XOR
// checksum over the written words; mismatch sets err[1] and the core is
// never started).
// Ports:
//   clk1, rst                      clock, synchronous active-high reset
//   load_req                       start a load from IDLE or DONE
//   s_valid/s_ready/s_data/s_last  program stream
//   mem_we/mem_addr/mem_wdata      instruction-memory write port
//   rf_we/rf_addr/rf_wdata         register-file write port
//   cpu_hold/cpu_start/cpu_halted  core control and status
//   done, err{tmo,cksum,ovf}, load_count, run_cycles   status
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int MEM_AW        = 10,
    parameter int RF_INIT_COUNT = 31,
    parameter int RUN_TIMEOUT   = 1024
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              load_req,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [INSN_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [INSN_W-1:0] mem_wdata,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [31:0]       rf_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    input  logic              cpu_halted,
    output logic              done,
    output logic [2:0]        err,
    output logic [MEM_AW:0]   load_count,
    output logic [15:0]       run_cycles
);

    localparam logic [MEM_AW:0] DEPTH_C   = {1'b1, {MEM_AW{1'b0}}};
    localparam logic [4:0]      RF_LAST_C = 5'(RF_INIT_COUNT - 1);
    localparam logic [31:0]     TMO_C     = 32'(RUN_TIMEOUT);
    localparam logic            TMO_EN_C  = (RUN_TIMEOUT != 0);
    localparam loader_state_e   FIRST_C   = (RF_INIT_COUNT == 0) ? ST_LOAD : ST_RF_INIT;
`ifdef MIPS32_LOADER_CKSUM_EN
    localparam logic            LAST_IS_CKSUM_C = 1'b1;
`else
    localparam logic            LAST_IS_CKSUM_C = 1'b0;
`endif

    loader_state_e state_r;
    loader_state_e state_s;
    logic [4:0]    rf_k_r;
    logic          accept_s;
    logic          full_s;
    logic          begin_s;
    logic          write_s;
    logic          ovf_s;
    logic          cksum_bad_s;
    logic          halt_s;
    logic          tmo_s;

`ifdef MIPS32_LOADER_CKSUM_EN
    logic cksum_match_s;

    mips32_loader_cksum u_cksum (
        .clk1     (clk1),
        .rst      (rst),
        .clear    (begin_s),
        .acc_en   (write_s),
        .acc_data (s_data),
        .cmp_data (s_data),
        .match    (cksum_match_s)
    );
`endif

    // Per-cycle events shared by the FSM and the datapath
    always_comb begin
        accept_s = s_valid && s_ready;
        full_s   = (load_count == DEPTH_C);
        begin_s  = load_req && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        // A full memory turns any accepted word into an overflow, including a last one
        write_s  = (state_r == ST_LOAD) && accept_s && !full_s && !(s_last && LAST_IS_CKSUM_C);
        ovf_s    = (state_r == ST_LOAD) && accept_s && full_s;
        // HALTED still shows the previous run during the first RUN cycle
        halt_s   = (state_r == ST_RUN) && cpu_halted && (run_cycles != 16'd0);
        tmo_s    = (state_r == ST_RUN) && TMO_EN_C && !halt_s &&
                   (({16'd0, run_cycles} + 32'd1) == TMO_C);
        cksum_bad_s = 1'b0;
`ifdef MIPS32_LOADER_CKSUM_EN
        cksum_bad_s = (state_r == ST_LOAD) && accept_s && s_last && !full_s && !cksum_match_s;
`endif
    end

    // State register
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (load_req) state_s = FIRST_C;
                else          state_s = state_r;
            end
            ST_RF_INIT: begin
                if (rf_k_r == RF_LAST_C) state_s = ST_LOAD;
                else                     state_s = ST_RF_INIT;
            end
            ST_LOAD: begin
                if (accept_s && full_s)      state_s = s_last ? ST_DONE : ST_DRAIN;
                else if (accept_s && s_last) state_s = ST_START;
                else                         state_s = ST_LOAD;
            end
            ST_DRAIN: begin
                if (accept_s && s_last) state_s = ST_DONE;
                else                    state_s = ST_DRAIN;
            end
            ST_START: begin
                if (err != 3'b000) state_s = ST_DONE;
                else               state_s = ST_RUN;
            end
            ST_RUN: begin
                if (halt_s || tmo_s) state_s = ST_DONE;
                else                 state_s = ST_RUN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the current state and this cycle's events
    always_comb begin
        s_ready   = (state_r == ST_LOAD) || (state_r == ST_DRAIN);
        mem_we    = write_s;
        mem_addr  = write_s ? load_count[MEM_AW-1:0] : {MEM_AW{1'b0}};
        mem_wdata = write_s ? s_data : {INSN_W{1'b0}};
        rf_we     = (state_r == ST_RF_INIT);
        rf_addr   = rf_we ? rf_k_r : 5'd0;
        rf_wdata  = rf_we ? {27'd0, rf_k_r} : 32'd0;
        cpu_start = (state_r == ST_START) && (err == 3'b000);
        cpu_hold  = !(cpu_start || (state_r == ST_RUN));
        done      = (state_r == ST_DONE);
    end

    // Counters and sticky error flags; load_req in IDLE/DONE clears them
    always_ff @(posedge clk1) begin
        if (rst) begin
            rf_k_r     <= 5'd0;
            load_count <= {(MEM_AW+1){1'b0}};
            run_cycles <= 16'd0;
            err        <= 3'b000;
        end else if (begin_s) begin
            rf_k_r     <= 5'd0;
            load_count <= {(MEM_AW+1){1'b0}};
            run_cycles <= 16'd0;
            err        <= 3'b000;
        end else begin
            if (rf_we)       rf_k_r <= rf_k_r + 5'd1;
            if (write_s)     load_count <= load_count + {{MEM_AW{1'b0}}, 1'b1};
            if (ovf_s)       err[ERR_OVF] <= 1'b1;
            if (cksum_bad_s) err[ERR_CKSUM] <= 1'b1;
            if (tmo_s)       err[ERR_TMO] <= 1'b1;
            if ((state_r == ST_RUN) && (run_cycles != 16'hFFFF)) begin
                run_cycles <= run_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
module tb_mips32_prog_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 50;
`ifdef MIPS32_LOADER_CKSUM_EN
    localparam bit CKSUM_MODE = 1'b1;
`else
    localparam bit CKSUM_MODE = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = 32'd0;
    logic          s_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          rf_we;
    logic [4:0]    rf_addr;
    logic [31:0]   rf_wdata;
    logic          cpu_hold;
    logic          cpu_start;
    logic          cpu_halted;
    logic          done;
    logic [2:0]    err;
    logic [AW:0]   load_count;
    logic [15:0]   run_cycles;

    int errors = 0;
    int checks = 0;

    wr_t         exp_q[$];
    logic [31:0] stim_q[$];
    wr_t         mon_w;
    int          exp_addr = 0;
    int          rf_exp = 0;
    int          rf_cnt = 0;
    int          start_cnt = 0;
    bit          never_halt = 1'b0;

    logic [31:0] prog [9] = '{32'h2801000A, 32'h28020014, 32'h28030019, 32'h0CE77800,
                              32'h0CE77800, 32'h00222000, 32'h0CE77800, 32'h00832800,
                              32'hFC000000};

    // core model state
    logic [31:0] regs [32];
    logic [31:0] tb_mem [DEPTH];
    logic [3:0]  pc;
    logic        running;
    logic        clr_pend;
    logic [31:0] insn;

    mips32_prog_loader #(.MEM_AW(AW), .RF_INIT_COUNT(31), .RUN_TIMEOUT(TMO)) dut (
        .clk1(clk1), .rst(rst), .load_req(load_req),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_halted(cpu_halted),
        .done(done), .err(err), .load_count(load_count), .run_cycles(run_cycles)
    );

    always #5 clk1 = ~clk1;

    // Tiny core: HALTED clears one cycle after the start pulse, one instruction per cycle
    always @(posedge clk1) begin
        if (rst) begin
            running    <= 1'b0;
            clr_pend   <= 1'b0;
            cpu_halted <= 1'b1;
            pc         <= 4'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 32'd0;
        end else begin
            if (rf_we) regs[rf_addr] <= rf_wdata;
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            clr_pend <= cpu_start;
            if (clr_pend) begin
                cpu_halted <= 1'b0;
                running    <= 1'b1;
                pc         <= 4'd0;
            end else if (running && !cpu_hold) begin
                insn = tb_mem[pc];
                case (insn[31:26])
                    6'h00: regs[insn[15:11]] <= regs[insn[25:21]] + regs[insn[20:16]];
                    6'h03: regs[insn[15:11]] <= regs[insn[25:21]] | regs[insn[20:16]];
                    6'h0A: regs[insn[20:16]] <= regs[insn[25:21]] + {{16{insn[15]}}, insn[15:0]};
                    6'h3F: if (!never_halt) begin
                        cpu_halted <= 1'b1;
                        running    <= 1'b0;
                    end
                    default: ;
                endcase
                pc <= pc + 4'd1;
            end else if (cpu_hold) begin
                running <= 1'b0;
            end
        end
    end

    // Scoreboard monitor: memory writes against the expected queue, rf seeding sequence
    initial forever begin
        @(negedge clk1);
        if (!rst) begin
            if (cpu_start) start_cnt++;
            if (mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write unexpected: got addr=%0d data=%h, expected none", mem_addr, mem_wdata);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (mem_addr !== mon_w.addr || mem_wdata !== mon_w.data) begin
                        errors++;
                        $display("FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 mem_addr, mem_wdata, mon_w.addr, mon_w.data);
                    end
                end
            end
            if (rf_we) begin
                checks++;
                if (rf_addr !== 5'(rf_exp) || rf_wdata !== 32'(rf_exp)) begin
                    errors++;
                    $display("FAIL rf_seed: got addr=%0d data=%h, expected k=%0d", rf_addr, rf_wdata, rf_exp);
                end
                rf_exp++;
                rf_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic pulse_load();
        exp_q.delete();
        rf_exp = 0; rf_cnt = 0; start_cnt = 0; exp_addr = 0;
        load_req = 1'b1;
        @(posedge clk1); #1;
        load_req = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        bit ok;
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk1); #1;
            cyc++;
            if (s_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_ready: s_ready still %b after %0d cycles, expected 1", s_ready, cyc);
        end
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk1);
            if (done === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, budget);
        end
    endtask

    task automatic add_cksum();
`ifdef MIPS32_LOADER_CKSUM_EN
        logic [31:0] x;
        x = 32'd0;
        foreach (stim_q[i]) x = x ^ stim_q[i];
        stim_q.push_back(x);
`endif
    endtask

    task automatic send_stream(input bit gaps, input bit chk_ready, input bit mark_last);
        for (int i = 0; i < stim_q.size(); i++) begin
            bit is_last;
            is_last = mark_last && (i == stim_q.size() - 1);
            s_valid = 1'b1;
            s_data  = stim_q[i];
            s_last  = is_last;
            if (exp_addr < DEPTH && !(is_last && CKSUM_MODE)) begin
                exp_q.push_back(wr_t'{addr: AW'(exp_addr), data: stim_q[i]});
                exp_addr++;
            end
            if (chk_ready) begin
                @(negedge clk1);
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL s_ready_word%0d: got %b, expected 1", i, s_ready);
                end
            end
            @(posedge clk1); #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (gaps) begin
                @(posedge clk1); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk1);
        #1;
        rst = 1'b0;
        @(negedge clk1);
        checks++;
        if ({cpu_hold, s_ready, done, cpu_start, mem_we, rf_we} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got hold,rdy,done,start,mwe,rwe=%b, expected 100000",
                     {cpu_hold, s_ready, done, cpu_start, mem_we, rf_we});
        end
        checks++;
        if (err !== 3'b000 || load_count !== 5'd0 || run_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_status: got err=%b cnt=%0d cyc=%0d, expected 0 0 0", err, load_count, run_cycles);
        end
        @(posedge clk1); #1;
    endtask

    task automatic test_baseline(input bit gaps);
        int cyc;
        never_halt = 1'b0;
        pulse_load();
        wait_ready(cyc);
        checks++;
        if (cyc != 31 || rf_cnt != 31) begin
            errors++;
            $display("FAIL rf_init_latency: got cycles=%0d writes=%0d, expected 31 31", cyc, rf_cnt);
        end
        stim_q.delete();
        foreach (prog[i]) stim_q.push_back(prog[i]);
        add_cksum();
        send_stream(gaps, 1'b0, 1'b1);
        wait_done(300);
        checks++;
        if (load_count !== 5'd9 || err !== 3'b000) begin
            errors++;
            $display("FAIL base_status gaps=%0d: got cnt=%0d err=%b, expected 9 000", gaps, load_count, err);
        end
        checks++;
        if (start_cnt != 1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL base_start gaps=%0d: got starts=%0d hold=%b, expected 1 1", gaps, start_cnt, cpu_hold);
        end
        checks++;
        if (regs[4] !== 32'd30 || regs[5] !== 32'd55) begin
            errors++;
            $display("FAIL base_regs gaps=%0d: got r4=%0d r5=%0d, expected 30 55", gaps, regs[4], regs[5]);
        end
        checks++;
        if (run_cycles !== 16'd11) begin
            errors++;
            $display("FAIL base_run_cycles: got %0d, expected 11", run_cycles);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL base_writes_missing: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_overflow(input int nwords);
        int cyc;
        pulse_load();
        wait_ready(cyc);
        stim_q.delete();
        for (int i = 0; i < nwords; i++) stim_q.push_back(32'hA000_0000 | 32'(i));
        send_stream(1'b0, 1'b1, 1'b1);
        wait_done(50);
        checks++;
        if (err !== 3'b001 || load_count !== 5'd16) begin
            errors++;
            $display("FAIL ovf%0d_status: got err=%b cnt=%0d, expected 001 16", nwords, err, load_count);
        end
        checks++;
        if (start_cnt != 0 || cpu_hold !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf%0d_ctrl: got starts=%0d hold=%b rdy=%b, expected 0 1 0",
                     nwords, start_cnt, cpu_hold, s_ready);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf%0d_writes_missing: got %0d pending, expected 0", nwords, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int cyc;
        never_halt = 1'b1;
        pulse_load();
        wait_ready(cyc);
        stim_q.delete();
        stim_q.push_back(32'h2801000A);
        stim_q.push_back(32'h0CE77800);
        add_cksum();
        send_stream(1'b0, 1'b0, 1'b1);
        wait_done(200);
        checks++;
        if (err !== 3'b100 || run_cycles !== 16'(TMO)) begin
            errors++;
            $display("FAIL timeout_status: got err=%b cyc=%0d, expected 100 %0d", err, run_cycles, TMO);
        end
        checks++;
        if (cpu_hold !== 1'b1 || start_cnt != 1 || load_count !== 5'd2) begin
            errors++;
            $display("FAIL timeout_ctrl: got hold=%b starts=%0d cnt=%0d, expected 1 1 2",
                     cpu_hold, start_cnt, load_count);
        end
        never_halt = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        pulse_load();
        wait_ready(cyc);
        stim_q.delete();
        for (int i = 0; i < 3; i++) stim_q.push_back(32'h0CE77800);
        send_stream(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk1); #1;
        checks++;
        if (cpu_hold !== 1'b1 || load_count !== 5'd0 || s_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: got hold=%b cnt=%0d rdy=%b done=%b, expected 1 0 0 0",
                     cpu_hold, load_count, s_ready, done);
        end
        rst = 1'b0;
        @(posedge clk1); #1;
        test_baseline(1'b0);
    endtask

`ifdef MIPS32_LOADER_CKSUM_EN
    task automatic test_cksum(input logic [31:0] ck, input logic [2:0] err_mask, input logic [2:0] err_exp,
                              input int starts_exp);
        int cyc;
        never_halt = 1'b1;
        pulse_load();
        wait_ready(cyc);
        stim_q.delete();
        stim_q.push_back(32'h0000_0011);
        stim_q.push_back(32'h0000_0022);
        stim_q.push_back(ck);
        send_stream(1'b0, 1'b0, 1'b1);
        wait_done(200);
        checks++;
        if ((err & err_mask) !== err_exp || load_count !== 5'd2 || start_cnt != starts_exp) begin
            errors++;
            $display("FAIL cksum_%h: got err=%b cnt=%0d starts=%0d, expected err&%b=%b cnt=2 starts=%0d",
                     ck, err, load_count, start_cnt, err_mask, err_exp, starts_exp);
        end
        never_halt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_baseline(1'b0);
        test_baseline(1'b1);
        test_overflow(18);
        test_overflow(17);
        test_timeout();
        test_reset_mid_load();
`ifdef MIPS32_LOADER_CKSUM_EN
        test_cksum(32'h0000_0033, 3'b011, 3'b000, 1);
        test_cksum(32'h0000_0034, 3'b111, 3'b010, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
